// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 decrypt core.
package aes_pkg;

    localparam int unsigned NR    = 10;
    localparam int unsigned KEY_W = 128;
    localparam int unsigned BLK_W = 128;

    localparam logic [3:0] LAST_CNT = 4'(NR - 1);

    typedef enum logic [1:0] {
        StIdle,
        StKeyExp,
        StRound
    } aes_state_e;

    // Round constant for the key-schedule step that produces round key (idx + 1).
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply built from an xtime chain (poly 0x11b).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] res;
        sq  = x;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Source byte index for InvShiftRows; byte k sits at row k%4, column k/4.
    function automatic int unsigned inv_shift_src(input int unsigned k);
        return 4 * (((k / 4) + 4 - (k % 4)) % 4) + (k % 4);
    endfunction

    // InvMixColumns on one column, byte 0 in bits [31:24].
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0]  a [4];
        logic [7:0]  m [4];
        logic [31:0] res;
        m   = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        res = '0;
        for (int j = 0; j < 4; j++) a[j] = col[31 - 8 * j -: 8];
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                res[31 - 8 * i -: 8] = res[31 - 8 * i -: 8] ^ gf_mul(a[j], m[(j + 4 - i) % 4]);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_sbox_dual.sv
// Single-byte AES S-box: forward when inv_i=0, inverse when inv_i=1.
module aes_sbox_dual
    import aes_pkg::*;
(
    input  logic       inv_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    logic [7:0] pre;
    logic [7:0] inv_v;

    // Inverse path undoes the affine map before inverting; forward path applies it after.
    always_comb begin
        pre = inv_i ? (rotl8(data_i, 1) ^ rotl8(data_i, 3) ^ rotl8(data_i, 6) ^ 8'h05) : data_i;
        inv_v = gf_inv(pre);
        data_o = inv_i ? inv_v
                       : (inv_v ^ rotl8(inv_v, 1) ^ rotl8(inv_v, 2) ^ rotl8(inv_v, 3)
                          ^ rotl8(inv_v, 4) ^ 8'h63);
    end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryptor: forward key expansion to rk10, then ten inverse rounds
// with the round key walked backwards on the fly.
// Optional AES_KEY_CACHE_EN keeps the last key and its rk10 so a repeated key skips expansion.
module aes_decrypt_core
    import aes_pkg::*;
(
    input  logic             AES_clk,
    input  logic             AES_rst,
    input  logic             AES_en,
    input  logic [BLK_W-1:0] AES_data_in,
    input  logic [KEY_W-1:0] AES_key_in,
    output logic [BLK_W-1:0] AES_data_out,
    output logic             AES_data_out_valid,
    output logic             AES_busy
);

    aes_state_e       st_q, st_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [BLK_W-1:0] state_q, state_d;
    logic [KEY_W-1:0] rk_q, rk_d;
    logic [BLK_W-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;

`ifdef AES_KEY_CACHE_EN
    logic [KEY_W-1:0] cache_key_q, cache_key_d;
    logic [KEY_W-1:0] cache_rk_q, cache_rk_d;
    logic             cache_vld_q, cache_vld_d;
`endif

    logic [31:0]      sw_in, sw_rot, sw_out;
    logic [7:0]       rc;
    logic [KEY_W-1:0] fwd_key, inv_key;
    logic [BLK_W-1:0] subbed, added, mixed, round_out;

    // Shared SubWord input: forward step uses w3, inverse step recovers w3 = v3 ^ v2 first.
    always_comb begin
        rc     = rcon(cnt_q);
        sw_in  = (st_q == StKeyExp) ? rk_q[31:0] : (rk_q[31:0] ^ rk_q[63:32]);
        sw_rot = {sw_in[23:0], sw_in[31:24]};
    end

    for (genvar i = 0; i < 4; i++) begin : g_key_sbox
        aes_sbox_dual u_sbox (
            .inv_i  (1'b0),
            .data_i (sw_rot[31 - 8 * i -: 8]),
            .data_o (sw_out[31 - 8 * i -: 8])
        );
    end

    for (genvar k = 0; k < 16; k++) begin : g_inv_sbox
        localparam int unsigned Src = inv_shift_src(k);
        aes_sbox_dual u_sbox (
            .inv_i  (1'b1),
            .data_i (state_q[BLK_W - 1 - 8 * Src -: 8]),
            .data_o (subbed[BLK_W - 1 - 8 * k -: 8])
        );
    end

    // Forward and inverse key-schedule steps plus the inverse round datapath.
    always_comb begin
        logic [31:0] v0;
        logic [31:0] w3;
        v0 = rk_q[127:96] ^ sw_out ^ {rc, 24'h0};
        fwd_key = {v0, v0 ^ rk_q[95:64], v0 ^ rk_q[95:64] ^ rk_q[63:32],
                   v0 ^ rk_q[95:64] ^ rk_q[63:32] ^ rk_q[31:0]};
        w3 = rk_q[31:0] ^ rk_q[63:32];
        inv_key = {rk_q[127:96] ^ sw_out ^ {rc, 24'h0}, rk_q[95:64] ^ rk_q[127:96],
                   rk_q[63:32] ^ rk_q[95:64], w3};
        added = subbed ^ inv_key;
        for (int c = 0; c < 4; c++) begin
            mixed[BLK_W - 1 - 32 * c -: 32] = inv_mix_col(added[BLK_W - 1 - 32 * c -: 32]);
        end
        round_out = (cnt_q == 4'd0) ? added : mixed;
    end

    // FSM next-state and datapath register updates.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        rk_d    = rk_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
`ifdef AES_KEY_CACHE_EN
        cache_key_d = cache_key_q;
        cache_rk_d  = cache_rk_q;
        cache_vld_d = cache_vld_q;
`endif
        unique case (st_q)
            StIdle: begin
                if (AES_en) begin
                    state_d = AES_data_in;
                    rk_d    = AES_key_in;
                    cnt_d   = 4'd0;
                    st_d    = StKeyExp;
`ifdef AES_KEY_CACHE_EN
                    if (cache_vld_q && (AES_key_in == cache_key_q)) begin
                        state_d = AES_data_in ^ cache_rk_q;
                        rk_d    = cache_rk_q;
                        cnt_d   = LAST_CNT;
                        st_d    = StRound;
                    end else begin
                        cache_key_d = AES_key_in;
                        cache_vld_d = 1'b0;
                    end
`endif
                end
            end
            StKeyExp: begin
                rk_d  = fwd_key;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = state_q ^ fwd_key;
                    cnt_d   = LAST_CNT;
                    st_d    = StRound;
`ifdef AES_KEY_CACHE_EN
                    cache_rk_d  = fwd_key;
                    cache_vld_d = 1'b1;
`endif
                end
            end
            StRound: begin
                state_d = round_out;
                rk_d    = inv_key;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    dout_d  = added;
                    valid_d = 1'b1;
                    cnt_d   = 4'd0;
                    st_d    = StIdle;
                end
            end
            default: st_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            st_q    <= StIdle;
            cnt_q   <= 4'd0;
            state_q <= '0;
            rk_q    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

`ifdef AES_KEY_CACHE_EN
    // Key cache registers; reset invalidates the cache.
    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            cache_key_q <= '0;
            cache_rk_q  <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            cache_key_q <= cache_key_d;
            cache_rk_q  <= cache_rk_d;
            cache_vld_q <= cache_vld_d;
        end
    end
`endif

    assign AES_data_out       = dout_q;
    assign AES_data_out_valid = valid_q;
    assign AES_busy           = (st_q != StIdle);

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Scoreboard bench for aes_decrypt_core: a behavioural AES-128 encryptor produces ciphertexts,
// the monitor checks each decrypted block and its accept-to-valid latency.
module tb_aes_decrypt_core;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [127:0] din = '0;
    logic [127:0] key = '0;
    logic [127:0] dout;
    logic         dvalid;
    logic         busy;

    aes_decrypt_core dut (
        .AES_clk            (clk),
        .AES_rst            (rst),
        .AES_en             (en),
        .AES_data_in        (din),
        .AES_key_in         (key),
        .AES_data_out       (dout),
        .AES_data_out_valid (dvalid),
        .AES_busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [127:0] pt;
        int           acc;
        int           lat;
    } exp_t;
    exp_t sb[$];

    logic [7:0]   sbox [256];
    logic         m_cache_vld = 1'b0;
    logic [127:0] m_cache_key = '0;
    logic [127:0] last_pt = '0;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K3  = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
    localparam logic [127:0] P3  = 128'h000000be000000000000000000000000;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] rl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Classic generator walk: p steps through powers of 3, q through powers of 1/3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    // Reference AES-128 encryption (FIPS-197 byte order).
    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]}
                      ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127 - 8 * b -: 8] ^ w[b / 4][31 - 8 * (b % 4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4 * c + r] = sbox[s[4 * ((c + r) % 4) + r]];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    if (rnd < 10)
                        s[4 * c + r] = xt(t[4 * c + r]) ^ xt(t[4 * c + (r + 1) % 4])
                                       ^ t[4 * c + (r + 1) % 4] ^ t[4 * c + (r + 2) % 4]
                                       ^ t[4 * c + (r + 3) % 4];
                    else
                        s[4 * c + r] = t[4 * c + r];
                end
            end
            for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4 * rnd + b / 4][31 - 8 * (b % 4) -: 8];
        end
        for (int b = 0; b < 16; b++) res[127 - 8 * b -: 8] = s[b];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called right after the accepting edge: records expectation and updates the key model.
    task automatic push_expect(input logic [127:0] k, input logic [127:0] pt);
        exp_t e;
        e.pt  = pt;
        e.acc = cyc;
        e.lat = 20;
`ifdef AES_KEY_CACHE_EN
        if (m_cache_vld && (m_cache_key == k)) e.lat = 10;
        m_cache_vld = 1'b1;
        m_cache_key = k;
`endif
        sb.push_back(e);
        last_pt = pt;
    endtask

    task automatic issue(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        en  = 1'b1;
        din = ct;
        key = k;
        @(posedge clk);
        #1;
        push_expect(k, pt);
        @(negedge clk);
        en = 1'b0;
        check("busy_after_accept", {127'd0, busy}, 128'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("completion_timeout", {96'd0, sb.size()}, 128'd0);
        repeat (3) @(negedge clk);
        check("dout_hold", dout, last_pt);
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && dvalid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: got data %h with nothing outstanding", dout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("plaintext", dout, e.pt);
                check("latency", 128'(cyc - e.acc), 128'(e.lat));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k, pt, kb, cb, pb;
        bit           found;
        build_sbox();

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dout", dout, 128'd0);
        check("reset_valid", {127'd0, dvalid}, 128'd0);
        check("reset_busy", {127'd0, busy}, 128'd0);
        rst = 1'b0;

        // Known-answer vectors and encryptor round trip
        issue(K1, C1, P1);
        wait_idle();
        issue(K2, C2, P2);
        wait_idle();
        issue(K3, aes_enc(K3, P3), P3);
        wait_idle();

        // Inputs toggled while busy are ignored; a request in the valid cycle is accepted
        kb = rnd128();
        pb = rnd128();
        cb = aes_enc(kb, pb);
        issue(K1, C1, P1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            en = 1'b1;
            if (dvalid) begin
                found = 1'b1;
                din = cb;
                key = kb;
            end else begin
                din = rnd128();
                key = rnd128();
            end
        end
        check("valid_seen_while_toggling", {127'd0, found}, 128'd1);
        @(posedge clk);
        #1;
        push_expect(kb, pb);
        @(negedge clk);
        en = 1'b0;
        wait_idle();

        // Reset mid-block aborts it
        issue(K1, C1, P1);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        m_cache_vld = 1'b0;
        @(negedge clk);
        check("abort_dout", dout, 128'd0);
        check("abort_valid", {127'd0, dvalid}, 128'd0);
        check("abort_busy", {127'd0, busy}, 128'd0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_no_result", dout, 128'd0);
        issue(K2, C2, P2);
        wait_idle();

        // Repeated key then new key (short latency only when the cache is built in)
        pt = rnd128();
        issue(K2, aes_enc(K2, pt), pt);
        wait_idle();
        issue(K1, C1, P1);
        wait_idle();

        // Randomised blocks, alternating fresh and repeated keys
        k = rnd128();
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) k = rnd128();
            pt = rnd128();
            issue(k, aes_enc(k, pt), pt);
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
